mem_port_arbiter: RTL and testbench

- Shares the single 32-bit memory port between instruction fetch (requester A, read-only) and load/store (requester B, read/write).
- Owns the port select that chooses between the fetch and data address/data buses, sequences each fixed-latency memory access, and returns read data with a one-cycle acknowledge.
- Sits between the fetch/execute stages and the memory.

---
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency 32-bit memory port between fetch (A) and load/store (B).
// Ties alternate round robin; define ARB_FIXED_PRIO_EN to make B win every tie instead.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_a,
    input  logic [31:0] addr_a,
    input  logic        req_b,
    input  logic [31:0] addr_b,
    input  logic        we_b,
    input  logic [31:0] wdata_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic [31:0] rdata,
    output logic        seletor,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       pick_b;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
    end

`ifdef ARB_FIXED_PRIO_EN
    assign pick_b = req_b;
`else
    assign pick_b = req_b & (~req_a | ~last_grant);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            rdata      <= '0;
            seletor    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: if (req_a || req_b) begin
                    seletor   <= pick_b;
                    mem_addr  <= pick_b ? addr_b : addr_a;
                    mem_we    <= pick_b & we_b;
                    mem_wdata <= pick_b ? wdata_b : '0;
                    mem_en    <= 1'b1;
                    cnt       <= 4'(MEM_LATENCY - 1);
                    state     <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    // mem_rdata is only valid in the final strobe cycle
                    if (cnt == 4'd0) begin
                        rdata  <= mem_rdata;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        ack_a  <= ~seletor;
                        ack_b  <= seletor;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= seletor;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;
    localparam int L = 2;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_a, req_b, we_b;
    logic [31:0] addr_a, addr_b, wdata_b, mem_rdata;
    logic        ack_a, ack_b, seletor, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .addr_a(addr_a),
        .req_b(req_b), .addr_b(addr_b), .we_b(we_b), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .seletor(seletor),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // model: one transaction occupies L strobe cycles then one ack cycle, counted from the grant
    bit          m_busy, m_owner, m_last, m_we;
    int          m_k;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic void m_reset();
        m_busy = 0; m_k = 0; m_owner = 0; m_last = 1; m_we = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endfunction

    function automatic void m_step();
        bit b;
        if (!m_busy) begin
            if (req_a || req_b) begin
                if (req_a && req_b) b = FIXED ? 1'b1 : !m_last;
                else b = req_b;
                m_owner = b;
                m_addr  = b ? addr_b : addr_a;
                m_we    = b && we_b;
                m_wdata = b ? wdata_b : 32'h0;
                m_busy  = 1;
                m_k     = 0;
            end
        end else begin
            if (m_k == L - 1) m_rdata = mem_rdata;
            if (m_k == L) begin
                m_last = m_owner;
                m_busy = 0;
            end else m_k++;
        end
    endfunction

    function automatic bit e_en();    return m_busy && m_k < L;               endfunction
    function automatic bit e_ack_a(); return m_busy && m_k == L && !m_owner;  endfunction
    function automatic bit e_ack_b(); return m_busy && m_k == L && m_owner;   endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mem_en", mem_en, e_en());
        chk("mem_we", mem_we, e_en() && m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("seletor", seletor, m_owner);
        chk("ack_a", ack_a, e_ack_a());
        chk("ack_b", ack_b, e_ack_b());
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic tick();
        if (reset) m_reset();
        else m_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        m_reset();
        compare_all();
        tick();
        reset = 0;
    endtask

    initial begin
        int n;
        bit got_a;
        reset = 1; req_a = 0; req_b = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_b = '0; mem_rdata = '0;
        m_reset();
        repeat (2) tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", rdata, 0);
        reset = 0;

        // single fetch
        mem_rdata = 32'hDEADBEEF; req_a = 1; addr_a = 32'h00400000;
        tick();
        chk("f_en1", mem_en, 1); chk("f_addr", mem_addr, 32'h00400000); chk("f_sel", seletor, 0);
        tick();
        chk("f_en2", mem_en, 1); chk("f_we", mem_we, 0);
        tick();
        chk("f_ack", ack_a, 1); chk("f_rdata", rdata, 32'hDEADBEEF); chk("f_en_off", mem_en, 0);
        req_a = 0;
        tick();
        chk("f_ack_once", ack_a, 0);

        // data write
        req_b = 1; addr_b = 32'h10010004; we_b = 1; wdata_b = 32'h12345678;
        tick();
        chk("w_we1", mem_we, 1); chk("w_wdata", mem_wdata, 32'h12345678); chk("w_sel", seletor, 1);
        tick();
        chk("w_we2", mem_we, 1); chk("w_addr", mem_addr, 32'h10010004);
        tick();
        chk("w_ack", ack_b, 1); chk("w_no_ack_a", ack_a, 0);
        req_b = 0; we_b = 0;
        tick();
        chk("w_ack_once", ack_b, 0);

        // contention from reset
        do_reset();
        req_a = 1; req_b = 1; addr_a = 32'h100; addr_b = 32'h200;
        n = 0;
        for (int i = 1; i <= 4 * (L + 2); i++) begin
            tick();
            if (ack_a || ack_b) begin
                chk($sformatf("rr_time%0d", n), i, (L + 1) + (L + 2) * n);
                chk($sformatf("rr_who%0d", n), ack_b, FIXED ? 1 : (n % 2));
                n++;
            end
        end
        chk("rr_count", n, 4);
        req_a = 0; req_b = 0;
        tick();

        // late arrival of A during B's access
        req_b = 1; addr_b = 32'h300;
        got_a = 0;
        for (int i = 1; i <= 2 * (L + 2); i++) begin
            tick();
            if (i == 1) begin req_a = 1; addr_a = 32'h400; end
            if (ack_b) begin chk("late_b_time", i, L + 1); req_b = 0; end
            if (ack_a) begin chk("late_a_time", i, 2 * L + 3); req_a = 0; got_a = 1; end
        end
        chk("late_a_seen", got_a, 1);

        // reset in the first access cycle
        req_a = 1; req_b = 1;
        tick();
        chk("mid_en_before", mem_en, 1);
        reset = 1;
        #1;
        chk("mid_en", mem_en, 0); chk("mid_sel", seletor, 0); chk("mid_addr", mem_addr, 0);
        chk("mid_ack", ack_a | ack_b, 0);
        m_reset();
        tick();
        reset = 0;
        for (int i = 1; i <= L + 1; i++) tick();
        chk("mid_first_ack", ack_a | ack_b, 1);
        chk("mid_first_who", ack_b, FIXED);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            mem_rdata = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            if (!req_a && $urandom_range(0, 3) == 0) begin req_a = 1; addr_a = $urandom; end
            if (!req_b && $urandom_range(0, 3) == 0) begin
                req_b = 1; addr_b = $urandom; we_b = $urandom; wdata_b = $urandom;
            end
            tick();
            if (e_ack_a()) begin
                if ($urandom_range(0, 1) == 0) req_a = 0;
                else addr_a = $urandom;
            end
            if (e_ack_b()) begin
                if ($urandom_range(0, 1) == 0) req_b = 0;
                else begin addr_b = $urandom; we_b = $urandom; wdata_b = $urandom; end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
